// File: rtl/mem_req_ctrl_if.sv
// Request/response handshake bundle between a client (master) and mem_req_ctrl (slave).
interface mem_req_ctrl_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mem_req_ctrl.sv
// Request front-end for a single-port, 1-cycle-latency memory: buffers requests,
// issues them in order, and returns read data through a credit-protected response FIFO.
module mem_req_ctrl #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int REQ_DEPTH  = 4,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_req_ctrl_if.slave         bus,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  idle
);
    localparam int REQ_PW = $clog2(REQ_DEPTH);
    localparam int RSP_PW = $clog2(RSP_DEPTH);
    localparam int RSP_DEPTH_I = RSP_DEPTH;
    localparam logic [RSP_PW+1:0] RSP_LIMIT = RSP_DEPTH_I[RSP_PW+1:0];

    logic [REQ_PW:0]       req_wp_q, req_wp_d, req_rp_q, req_rp_d;
    logic [RSP_PW:0]       rsp_wp_q, rsp_wp_d, rsp_rp_q, rsp_rp_d;
    logic                  rd_pending_q, rd_pending_d;

    logic                  req_wr_q    [REQ_DEPTH];
    logic [ADDR_WIDTH-1:0] req_addr_q  [REQ_DEPTH];
    logic [DATA_WIDTH-1:0] req_wdata_q [REQ_DEPTH];
    logic [DATA_WIDTH-1:0] rsp_data_q  [RSP_DEPTH];

    logic                  req_empty, req_full, req_push;
    logic                  rsp_empty, rsp_push, rsp_pop;
    logic                  head_write, can_rd, issue;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic [RSP_PW:0]       rsp_count;
    logic [RSP_PW+1:0]     rsp_used;

    // Request FIFO status; ready depends only on stored state, never on this cycle's issue.
    assign req_empty     = (req_wp_q == req_rp_q);
    assign req_full      = (req_wp_q[REQ_PW] != req_rp_q[REQ_PW]) &&
                           (req_wp_q[REQ_PW-1:0] == req_rp_q[REQ_PW-1:0]);
    assign bus.req_ready = !req_full;
    assign req_push      = bus.req_valid && !req_full;

    assign head_write = req_wr_q[req_rp_q[REQ_PW-1:0]];
    assign head_addr  = req_addr_q[req_rp_q[REQ_PW-1:0]];
    assign head_wdata = req_wdata_q[req_rp_q[REQ_PW-1:0]];

    // Read credit counts stored responses plus the one in flight; a same-cycle pop earns nothing.
    assign rsp_count = rsp_wp_q - rsp_rp_q;
    assign rsp_used  = {1'b0, rsp_count} + {{(RSP_PW+1){1'b0}}, rd_pending_q};
    assign can_rd    = (rsp_used < RSP_LIMIT);
    assign issue     = !req_empty && (head_write || can_rd);

    assign rsp_empty     = (rsp_wp_q == rsp_rp_q);
    assign bus.rsp_valid = !rsp_empty;
    assign bus.rsp_rdata = rsp_data_q[rsp_rp_q[RSP_PW-1:0]];
    assign rsp_pop       = !rsp_empty && bus.rsp_ready;
    assign rsp_push      = rd_pending_q;

    assign idle = req_empty && rsp_empty && !rd_pending_q;

    // Memory pins: driven from the FIFO head only in an issuing cycle, zero otherwise.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        if (issue) begin
            mem_addr  = head_addr;
            mem_wdata = head_wdata;
            mem_wr_en = head_write;
            mem_rd_en = !head_write;
        end
    end

    // Next-state for FIFO pointers and the read-in-flight flag.
    always_comb begin
        req_wp_d     = req_wp_q + {{REQ_PW{1'b0}}, req_push};
        req_rp_d     = req_rp_q + {{REQ_PW{1'b0}}, issue};
        rsp_wp_d     = rsp_wp_q + {{RSP_PW{1'b0}}, rsp_push};
        rsp_rp_d     = rsp_rp_q + {{RSP_PW{1'b0}}, rsp_pop};
        rd_pending_d = issue && !head_write;
    end

    // Control state; reset discards queued requests, in-flight reads and unread responses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_wp_q     <= '0;
            req_rp_q     <= '0;
            rsp_wp_q     <= '0;
            rsp_rp_q     <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            req_wp_q     <= req_wp_d;
            req_rp_q     <= req_rp_d;
            rsp_wp_q     <= rsp_wp_d;
            rsp_rp_q     <= rsp_rp_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    // Request storage, written at the tail on push.
    always_ff @(posedge clk) begin
        if (req_push) begin
            req_wr_q[req_wp_q[REQ_PW-1:0]]    <= bus.req_write;
            req_addr_q[req_wp_q[REQ_PW-1:0]]  <= bus.req_addr;
            req_wdata_q[req_wp_q[REQ_PW-1:0]] <= bus.req_wdata;
        end
    end

    // Response storage captures memory read data; cleared so rsp_rdata reads zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RSP_DEPTH; i++) rsp_data_q[i] <= '0;
        end else if (rsp_push) begin
            rsp_data_q[rsp_wp_q[RSP_PW-1:0]] <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed and random bench for mem_req_ctrl with a resettable 1-cycle-latency memory model.
module tb_mem_req_ctrl;
    localparam int AW = 2;
    localparam int DW = 8;
    localparam int RSP_DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en, mem_rd_en;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          idle;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem_arr [4];
    logic [DW-1:0] mdl_mem [4];
    logic [DW-1:0] got [$];
    logic [DW-1:0] exp_q [$];
    int occ = 0, rd_cnt = 0, both_viol = 0, full_viol = 0, occ_viol = 0;
    logic rd_prev = 1'b0;

    always #5 clk = ~clk;

    mem_req_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REQ_DEPTH(4), .RSP_DEPTH(RSP_DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mem_addr (mem_addr),
        .mem_wr_en(mem_wr_en),
        .mem_rd_en(mem_rd_en),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .idle     (idle)
    );

    // Single-port memory: write or read sampled at the edge, read data valid the next cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem_arr[i] <= '0;
            mem_rdata <= '0;
        end else begin
            if (mem_wr_en) mem_arr[mem_addr] <= mem_wdata;
            if (mem_rd_en) mem_rdata <= mem_arr[mem_addr];
        end
    end

    // Response collector and protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            occ     <= 0;
            rd_prev <= 1'b0;
        end else begin
            if (mem_wr_en && mem_rd_en) both_viol <= both_viol + 1;
            if (bus.rsp_valid != (occ != 0)) occ_viol <= occ_viol + 1;
            if (rd_prev && occ >= RSP_DEPTH) full_viol <= full_viol + 1;
            if (bus.rsp_valid && bus.rsp_ready) got.push_back(bus.rsp_rdata);
            occ     <= occ + (rd_prev ? 1 : 0) - ((bus.rsp_valid && bus.rsp_ready) ? 1 : 0);
            rd_prev <= mem_rd_en;
            if (mem_rd_en) rd_cnt <= rd_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Drive one request from posedge+1 until accepted; returns at posedge+1 after the accept edge.
    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) chk("req_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target, input string tag);
        int n = 0;
        while (got.size() < target && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (got.size() < target) chk(tag, got.size(), target);
    endtask

    initial begin
        #2000000;
        chk("watchdog", 32'd1, 32'd0);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, lat, rd0;
        logic [DW-1:0] e2 [4];
        logic [DW-1:0] e3 [6];
        logic [AW-1:0] a;
        logic acc;

        e2 = '{8'h11, 8'h22, 8'h33, 8'h44};
        e3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};

        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_wr_en", mem_wr_en, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_idle", idle, 1);
        chk("rst_rdata", bus.rsp_rdata, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Test 1: write then read addr 2, latency from read acceptance.
        base = got.size();
        bus.rsp_ready = 1'b1;
        send(1'b1, 2'd2, 8'hA5);
        send(1'b0, 2'd2, 8'h00);
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        @(posedge clk);
        #1;
        chk("t1_latency", lat, 3);
        repeat (4) @(posedge clk);
        #1;
        chk("t1_count", got.size() - base, 1);
        chk("t1_data", got[base], 8'hA5);

        // Test 2: four writes then four reads, responses in order.
        base = got.size();
        for (int i = 0; i < 4; i++) send(1'b1, i[1:0], e2[i]);
        for (int i = 0; i < 4; i++) send(1'b0, i[1:0], 8'h00);
        wait_rsp(base + 4, "t2_timeout");
        for (int i = 0; i < 4; i++) chk("t2_data", got[base + i], e2[i]);

        // Test 3: six reads with consumer stalled; only two may issue.
        repeat (3) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        base = got.size();
        rd0 = rd_cnt;
        for (int i = 0; i < 6; i++) send(1'b0, i[1:0], 8'h00);
        repeat (3) begin
            @(negedge clk);
            chk("t3_rd_stall", mem_rd_en, 0);
        end
        chk("t3_req_full", bus.req_ready, 0);
        @(posedge clk);
        #1;
        chk("t3_rd_issued", rd_cnt - rd0, 2);
        bus.rsp_ready = 1'b1;
        wait_rsp(base + 6, "t3_timeout");
        for (int i = 0; i < 6; i++) chk("t3_data", got[base + i], e3[i]);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_count", got.size() - base, 6);
        chk("t3_idle", idle, 1);

        // Test 4: write then read of the same address on consecutive cycles.
        base = got.size();
        send(1'b1, 2'd1, 8'h5A);
        send(1'b0, 2'd1, 8'h00);
        wait_rsp(base + 1, "t4_timeout");
        chk("t4_data", got[base], 8'h5A);

        // Test 5: reset while requests are queued and a read is in flight.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) send(1'b0, i[1:0], 8'h00);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rsp_valid", bus.rsp_valid, 0);
        chk("t5_rd_en", mem_rd_en, 0);
        chk("t5_wr_en", mem_wr_en, 0);
        chk("t5_idle", idle, 1);
        chk("t5_req_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) mdl_mem[i] = '0;
        base = got.size();
        send(1'b0, 2'd3, 8'h00);
        wait_rsp(base + 1, "t5_timeout");
        repeat (4) @(posedge clk);
        #1;
        chk("t5_count", got.size() - base, 1);
        chk("t5_data", got[base], 8'h00);

        // Test 6: random traffic against the reference model.
        base = got.size();
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            if (!bus.req_valid && $urandom_range(0, 2) != 0) begin
                bus.req_valid = 1'b1;
                bus.req_write = ($urandom_range(0, 1) == 1);
                a = 2'($urandom_range(0, 3));
                bus.req_addr  = a;
                bus.req_wdata = 8'($urandom_range(0, 255));
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = bus.req_valid && bus.req_ready;
            if (acc) begin
                if (bus.req_write) mdl_mem[bus.req_addr] = bus.req_wdata;
                else exp_q.push_back(mdl_mem[bus.req_addr]);
            end
            @(posedge clk);
            #1;
            if (acc) bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 100 && !idle; n++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("t6_idle", idle, 1);
        chk("t6_count", got.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) chk("t6_data", got[base + i], exp_q[i]);
        chk("t6_wr_rd_both", both_viol, 0);
        chk("t6_push_full", full_viol, 0);
        chk("t6_rsp_valid_occ", occ_viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
